univ_shift_counter: RTL and testbench
=====================================

UNIV_SHIFT_COUNTER -- requirements
Module: univ_shift_counter

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range 2..32.
REQ-002 Parameter AW, default $clog2(WIDTH), width of the shift-amount port.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; 0 = hold all state.
REQ-006 A  input  4  mode select (Function table).
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 RSI  input  1  serial in for shift left (enters LSB).
REQ-009 LSI  input  1  serial in for shift right (enters MSB).
REQ-010 amt  input  AW  rotate amount for the barrel-rotate mode.
REQ-011 Q  output  WIDTH  registered register contents.
REQ-012 SO  output  1  registered bit last shifted or rotated out.
REQ-013 CO  output  1  registered carry/borrow pulse from counting.

Function
REQ-014 With en=1, Q SHALL take the following next value at each rising edge:
- 0000 hold
- 0001 shift left, LSB<=RSI
- 0010 shift right, MSB<=LSI
- 0011 clear to 0
- 0100 preset to all ones
- 0101 count up, modulo 2^WIDTH
- 0110 count down, modulo 2^WIDTH
- 0111 parallel load D
- 1000 rotate left by 1
- 1001 rotate right by 1
- 1010 arithmetic shift right (MSB replicated)
- 1011 rotate left by amt (amt modulo WIDTH)
- 1100 saturating count up
- 1101 saturating count down
- 1110 and 1111 hold (reserved)
REQ-015 Latency SHALL be one cycle: Q, SO and CO reflect the operation at the edge where it is sampled.
REQ-016 SO SHALL capture the departing bit on shift/rotate modes:
- old MSB on 0001 and 1000
- old LSB on 0010, 1001 and 1010
- old Q[WIDTH-amt] on 1011 with amt!=0, else 0
SO SHALL hold its value in all other modes.
REQ-017 CO SHALL be 1 for exactly one cycle when 0101 wraps all-ones->0 or 0110 wraps 0->all-ones; otherwise it SHALL be 0, including when en=0.
REQ-018 Saturating modes SHALL hold at all-ones (1100) or at 0 (1101) with CO=0.
REQ-019 With en=0, Q and SO SHALL hold regardless of A, and CO SHALL be 0.
REQ-020 amt SHALL be ignored in every mode except 1011; 1011 with amt=0 SHALL leave Q unchanged.

Reset
REQ-021 reset=1 at a rising edge SHALL set Q=0, SO=0 and CO=0, overriding en and A.
REQ-022 Deasserting reset mid-sequence SHALL resume operation from Q=0 on the next edge with no residual state.

Structure
REQ-023 Mode encodings SHALL be named constants in shared package usr_pkg.
REQ-024 Rotate-by-amt logic SHALL be a combinational sub-module usr_barrel_rot, parameterised by WIDTH.
REQ-025 Only Q, SO and CO SHALL be registers; no other state SHALL exist.

Verification (WIDTH=8)
REQ-026 reset=1 for 2 edges with A=0111, D=A5 -> Q=00, SO=0, CO=0.
REQ-027 Load A5, then 1000 -> Q=4B, SO=1; then 1001 -> Q=A5, SO=1.
REQ-028 Load 80, then 1010 -> Q=C0; then 1011 with amt=3 -> Q=06, SO=0.
REQ-029 Load FF, then 0101 -> Q=00, CO=1 for one cycle; load FF, then 1100 -> Q=FF, CO=0.
REQ-030 Clear, then 0110 -> Q=FF, CO=1; clear, then 1101 -> Q=00, CO=0.
REQ-031 Load 3C, set en=0 with A=0101 for 3 edges -> Q=3C, CO=0; then en=1 -> Q=3D.

Source files
------------

// File: rtl/univ_shift_counter_pkg.sv
// ============================================================================
// Module  : usr_pkg
// Brief   : Mode encodings shared by the universal shift/counter register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    localparam int MODE_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD    = 4'b0000,
        MODE_SHL     = 4'b0001,
        MODE_SHR     = 4'b0010,
        MODE_CLR     = 4'b0011,
        MODE_SET     = 4'b0100,
        MODE_CNT_UP  = 4'b0101,
        MODE_CNT_DN  = 4'b0110,
        MODE_LOAD    = 4'b0111,
        MODE_ROL1    = 4'b1000,
        MODE_ROR1    = 4'b1001,
        MODE_ASR     = 4'b1010,
        MODE_ROL_AMT = 4'b1011,
        MODE_SAT_UP  = 4'b1100,
        MODE_SAT_DN  = 4'b1101,
        MODE_RSV0    = 4'b1110,
        MODE_RSV1    = 4'b1111
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/univ_shift_counter_if.sv
// ============================================================================
// Module  : univ_shift_counter_if
// Brief   : Control/data bundle between a driver and the shift/counter register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface univ_shift_counter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
);
    logic             en;
    logic [3:0]       A;
    logic [WIDTH-1:0] D;
    logic             RSI;
    logic             LSI;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             CO;

    modport master (
        output en, A, D, RSI, LSI, amt,
        input  Q, SO, CO
    );

    modport slave (
        input  en, A, D, RSI, LSI, amt,
        output Q, SO, CO
    );
endinterface

`default_nettype wire

// File: rtl/univ_shift_counter_barrel_rot.sv
// ============================================================================
// Module  : usr_barrel_rot
// Brief   : Combinational rotate-left by a variable amount, plus departing bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_barrel_rot #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] i_q,
    input  wire logic [AW-1:0]    i_amt,
    output logic      [WIDTH-1:0] o_rot,
    output logic                  o_out_bit
);
    logic [31:0]        w_sh;
    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH:0]     w_top;

    assign w_sh  = 32'(i_amt) % 32'(WIDTH);
    assign w_dbl = {i_q, i_q} << w_sh;
    assign o_rot = w_dbl[2*WIDTH-1:WIDTH];

    // Bit WIDTH of the widened shift is the last bit pushed out: Q[WIDTH-sh], or 0 when sh=0
    assign w_top     = {1'b0, i_q} << w_sh;
    assign o_out_bit = w_top[WIDTH];
endmodule

`default_nettype wire

// File: rtl/univ_shift_counter.sv
// ============================================================================
// Module  : univ_shift_counter
// Brief   : 16-mode universal shift register / counter with registered SO/CO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  wire logic              Clk,
    input  wire logic              reset,
    univ_shift_counter_if.slave    bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_so;
    logic             r_co;
    logic [WIDTH-1:0] w_rot;
    logic             w_rot_out;

    usr_barrel_rot #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_rot (
        .i_q       (r_q),
        .i_amt     (bus.amt),
        .o_rot     (w_rot),
        .o_out_bit (w_rot_out)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_q  <= '0;
            r_so <= 1'b0;
            r_co <= 1'b0;
        end else begin
            r_co <= 1'b0;
            if (bus.en) begin
                case (bus.A)
                    MODE_SHL: begin
                        r_q  <= {r_q[WIDTH-2:0], bus.RSI};
                        r_so <= r_q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        r_q  <= {bus.LSI, r_q[WIDTH-1:1]};
                        r_so <= r_q[0];
                    end
                    MODE_CLR:  r_q <= '0;
                    MODE_SET:  r_q <= '1;
                    MODE_CNT_UP: begin
                        r_q  <= r_q + WIDTH'(1);
                        r_co <= &r_q;
                    end
                    MODE_CNT_DN: begin
                        r_q  <= r_q - WIDTH'(1);
                        r_co <= ~|r_q;
                    end
                    MODE_LOAD: r_q <= bus.D;
                    MODE_ROL1: begin
                        r_q  <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        r_so <= r_q[WIDTH-1];
                    end
                    MODE_ROR1: begin
                        r_q  <= {r_q[0], r_q[WIDTH-1:1]};
                        r_so <= r_q[0];
                    end
                    MODE_ASR: begin
                        r_q  <= {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                        r_so <= r_q[0];
                    end
                    MODE_ROL_AMT: begin
                        r_q  <= w_rot;
                        r_so <= w_rot_out;
                    end
                    // Saturating counters stop at the rail and never raise CO
                    MODE_SAT_UP: if (r_q != '1) r_q <= r_q + WIDTH'(1);
                    MODE_SAT_DN: if (r_q != '0) r_q <= r_q - WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

    assign bus.Q  = r_q;
    assign bus.SO = r_so;
    assign bus.CO = r_co;
endmodule

`default_nettype wire

// File: tb/tb_univ_shift_counter.sv
// ============================================================================
// Module  : tb_univ_shift_counter
// Brief   : Table-driven directed bench for univ_shift_counter at WIDTH=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_counter;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] a;
        logic [7:0] d;
        logic       rsi;
        logic       lsi;
        logic [2:0] amt;
        logic [7:0] q;
        logic       so;
        logic       co;
    } vec_t;

    localparam int NV = 45;

    logic Clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [NV];

    univ_shift_counter_if #(.WIDTH(8), .AW(3)) bus ();

    univ_shift_counter #(.WIDTH(8), .AW(3)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] a,
                                input logic [7:0] d, input logic rsi, input logic lsi,
                                input logic [2:0] amt, input logic [7:0] q,
                                input logic so, input logic co);
        vec_t v;
        v.rst = rst; v.en = en; v.a = a; v.d = d; v.rsi = rsi; v.lsi = lsi;
        v.amt = amt; v.q = q; v.so = so; v.co = co;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [3:0] a,
                         input logic [7:0] d, input logic rsi, input logic lsi,
                         input logic [2:0] amt);
        reset   = rst;
        bus.en  = en;
        bus.A   = a;
        bus.D   = d;
        bus.RSI = rsi;
        bus.LSI = lsi;
        bus.amt = amt;
    endtask

    task automatic check(input string name, input logic [7:0] q, input logic so, input logic co);
        n_cmp++;
        if (bus.Q !== q) begin
            n_bad++;
            $display("FAIL %s Q: got %02h expected %02h", name, bus.Q, q);
        end
        n_cmp++;
        if (bus.SO !== so) begin
            n_bad++;
            $display("FAIL %s SO: got %b expected %b", name, bus.SO, so);
        end
        n_cmp++;
        if (bus.CO !== co) begin
            n_bad++;
            $display("FAIL %s CO: got %b expected %b", name, bus.CO, co);
        end
    endtask

    task automatic step_check(input string name, input logic rst, input logic en,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] q, input logic so, input logic co);
        drive(rst, en, a, d, 1'b0, 1'b0, 3'd0);
        @(posedge Clk);
        #1;
        check(name, q, so, co);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //              rst   en    A      D      rsi   lsi   amt   Q      SO    CO
        vecs[0]  = mk(1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 4'h7, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 4'h8, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4B, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 4'h9, 8'h00, 1'b0, 1'b0, 3'd0, 8'hA5, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 4'h7, 8'h80, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 4'hA, 8'h00, 1'b0, 1'b0, 3'd0, 8'hC0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 3'd3, 8'h06, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 4'h7, 8'hFF, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 4'h7, 8'hFF, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 4'hC, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 4'h6, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 4'hD, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 4'h7, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h3C, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h3C, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h3C, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h3C, 1'b0, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h3D, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h7B, 1'b0, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 4'h2, 8'h00, 1'b0, 1'b1, 3'd0, 8'hBD, 1'b1, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        vecs[25] = mk(1'b0, 1'b1, 4'hE, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        vecs[26] = mk(1'b0, 1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0);
        vecs[27] = mk(1'b0, 1'b1, 4'h8, 8'h00, 1'b0, 1'b0, 3'd5, 8'hFF, 1'b1, 1'b0);
        vecs[28] = mk(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        vecs[29] = mk(1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        vecs[30] = mk(1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[31] = mk(1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[32] = mk(1'b0, 1'b1, 4'h7, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
        vecs[33] = mk(1'b0, 1'b1, 4'hD, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[34] = mk(1'b0, 1'b1, 4'hD, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[35] = mk(1'b0, 1'b1, 4'h6, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b1);
        vecs[36] = mk(1'b0, 1'b1, 4'h6, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFE, 1'b1, 1'b0);
        vecs[37] = mk(1'b0, 1'b1, 4'hC, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        vecs[38] = mk(1'b0, 1'b1, 4'hC, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        vecs[39] = mk(1'b0, 1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 3'd1, 8'hFF, 1'b1, 1'b0);
        vecs[40] = mk(1'b0, 1'b1, 4'h7, 8'h81, 1'b0, 1'b0, 3'd0, 8'h81, 1'b1, 1'b0);
        vecs[41] = mk(1'b0, 1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 3'd7, 8'hC0, 1'b0, 1'b0);
        vecs[42] = mk(1'b0, 1'b1, 4'hB, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 1'b1, 1'b0);
        vecs[43] = mk(1'b0, 1'b1, 4'hA, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
        vecs[44] = mk(1'b0, 1'b1, 4'hA, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        drive(1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].d,
                  vecs[i].rsi, vecs[i].lsi, vecs[i].amt);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].q, vecs[i].so, vecs[i].co);
        end

        // Reset in mid-count with en=0 must clear SO too, then counting restarts from 0
        step_check("mid_load",  1'b0, 1'b1, 4'h7, 8'h55, 8'h55, 1'b1, 1'b0);
        step_check("mid_count", 1'b0, 1'b1, 4'h5, 8'h00, 8'h56, 1'b1, 1'b0);
        step_check("mid_reset", 1'b1, 1'b0, 4'h5, 8'h00, 8'h00, 1'b0, 1'b0);
        step_check("resume",    1'b0, 1'b1, 4'h5, 8'h00, 8'h01, 1'b0, 1'b0);

        // Wrap pulse lasts exactly one cycle across back-to-back counting
        step_check("wrap_load", 1'b0, 1'b1, 4'h7, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step_check("wrap_up",   1'b0, 1'b1, 4'h5, 8'h00, 8'h00, 1'b0, 1'b1);
        step_check("after_up",  1'b0, 1'b1, 4'h5, 8'h00, 8'h01, 1'b0, 1'b0);
        step_check("back_dn",   1'b0, 1'b1, 4'h6, 8'h00, 8'h00, 1'b0, 1'b0);
        step_check("wrap_dn",   1'b0, 1'b1, 4'h6, 8'h00, 8'hFF, 1'b0, 1'b1);
        step_check("after_dn",  1'b0, 1'b1, 4'h0, 8'h00, 8'hFF, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
